spi_txn_arbiter: RTL and testbench

//  Shares one SPI master (32-bit MOSI/MISO word, 6-bit bit-count, request/ready handshake) between

---
 rtl/spi_txn_arbiter_pkg.sv | 22 ++
 rtl/spi_txn_arbiter_rr_pick.sv | 38 +++
 rtl/spi_txn_arbiter.sv | 177 +++++++++++++++++
 tb/tb_spi_txn_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_txn_arbiter_pkg.sv
// Shared types and default widths for the SPI transaction arbiter.
// State encodings are fixed: IDLE=0, ISSUE=1, WAIT=2, DONE=3.
package spi_txn_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    localparam int DEF_NREQ    = 2;
    localparam int DEF_DW      = 32;
    localparam int DEF_NBW     = 6;
    localparam int DEF_TIMEOUT = 1023;

    // Width of an index able to address n items; never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_txn_arbiter_rr_pick.sv
// spi_rr_pick: combinational round-robin picker.
// Searches upward from rr_last+1 (mod NREQ) and returns the first pending
// requester as a one-hot grant plus its index; any is high if anything is pending.
module spi_rr_pick
    import spi_txn_arbiter_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IW   = idx_width(DEF_NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_last,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);

    int          cand;
    logic [IW-1:0] cand_idx;

    // Scan all NREQ positions starting just after the last owner; first hit wins.
    always_comb begin
        grant    = '0;
        idx      = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand     = (int'(rr_last) + k) % NREQ;
            cand_idx = IW'(cand);
            if (!any && req[cand_idx]) begin
                any             = 1'b1;
                grant[cand_idx] = 1'b1;
                idx             = cand_idx;
            end
        end
    end

endmodule

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: shares one SPI master between NREQ requesters.
// Round-robin grant, one transaction in flight, MISO word routed to the owner.
// Optional WAIT watchdog enabled by defining SPI_ARB_TIMEOUT_EN; without it
// WAIT is unbounded and rsp_err is tied low.
//
//  state | meaning
//  IDLE  | no transaction; grant the next pending requester, capture its payload
//  ISSUE | payload captured and acked; start pulse to the master is launched
//  WAIT  | frame in progress; waiting for spi_ready (or watchdog expiry)
//  DONE  | response pulse visible to the owner; back to IDLE next cycle
module spi_txn_arbiter
    import spi_txn_arbiter_pkg::*;
#(
    parameter int NREQ           = DEF_NREQ,
    parameter int DW             = DEF_DW,
    parameter int NBW            = DEF_NBW,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
    input  logic                clk_in,
    input  logic                nrst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*DW-1:0]  req_mosi,
    input  logic [NREQ*NBW-1:0] req_nbits,
    output logic [NREQ-1:0]     req_ack,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [DW-1:0]       rsp_miso,
    output logic                rsp_err,
    output logic                busy,
    output logic [DW-1:0]       spi_mosi_data,
    output logic [NBW-1:0]      spi_nbits,
    output logic                spi_request,
    input  logic                spi_ready,
    input  logic [DW-1:0]       spi_miso_data
);

    localparam int IW = idx_width(NREQ);

    arb_state_e    state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] rr_last_q, rr_last_d;

    logic [NREQ-1:0] ack_d;
    logic [NREQ-1:0] rspv_d;
    logic [DW-1:0]   miso_d;
    logic [DW-1:0]   mosi_d;
    logic [NBW-1:0]  nbits_d;
    logic            spi_req_d;

    logic [NREQ-1:0] pick_grant;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;

    spi_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req     (req_valid),
        .rr_last (rr_last_q),
        .grant   (pick_grant),
        .idx     (pick_idx),
        .any     (pick_any)
    );

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TW = idx_width(TIMEOUT_CYCLES);
    // Down-counter loaded in ISSUE; expiry is the terminal count seen in WAIT.
    localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] cnt_q, cnt_d;
    logic          err_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign rsp_err = 1'b0;
`endif

    // Next-state and next-output logic; pulses default low, data outputs hold.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        mosi_d    = spi_mosi_data;
        nbits_d   = spi_nbits;
        miso_d    = rsp_miso;
        ack_d     = '0;
        rspv_d    = '0;
        spi_req_d = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    mosi_d  = req_mosi[pick_idx*DW +: DW];
                    nbits_d = req_nbits[pick_idx*NBW +: NBW];
                    owner_d = pick_idx;
                    ack_d   = pick_grant;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                spi_req_d = 1'b1;
                state_d   = ST_WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
                cnt_d     = TO_LOAD;
`endif
            end
            ST_WAIT: begin
                if (spi_ready) begin
                    miso_d          = spi_miso_data;
                    rspv_d[owner_q] = 1'b1;
                    rr_last_d       = owner_q;
                    state_d         = ST_DONE;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (cnt_q == '0) begin
                    miso_d          = '0;
                    rspv_d[owner_q] = 1'b1;
                    err_d           = 1'b1;
                    rr_last_d       = owner_q;
                    state_d         = ST_DONE;
                end else begin
                    cnt_d = cnt_q - TW'(1);
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; rr_last resets so requester 0 wins first.
    always_ff @(posedge clk_in) begin
        if (!nrst) begin
            state_q       <= ST_IDLE;
            owner_q       <= '0;
            rr_last_q     <= IW'(NREQ - 1);
            req_ack       <= '0;
            rsp_valid     <= '0;
            rsp_miso      <= '0;
            busy          <= 1'b0;
            spi_mosi_data <= '0;
            spi_nbits     <= '0;
            spi_request   <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_last_q     <= rr_last_d;
            req_ack       <= ack_d;
            rsp_valid     <= rspv_d;
            rsp_miso      <= miso_d;
            busy          <= (state_d != ST_IDLE);
            spi_mosi_data <= mosi_d;
            spi_nbits     <= nbits_d;
            spi_request   <= spi_req_d;
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    // Watchdog counter and error flag accompanying the response pulse.
    always_ff @(posedge clk_in) begin
        if (!nrst) begin
            cnt_q   <= '0;
            rsp_err <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            rsp_err <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter (NREQ=2, TIMEOUT_CYCLES=16).
// Watchdog cases run only when SPI_ARB_TIMEOUT_EN is defined; otherwise the
// unbounded-WAIT behaviour is checked instead.
module tb_spi_txn_arbiter;

    localparam int NREQ = 2;
    localparam int DW   = 32;
    localparam int NBW  = 6;

    localparam logic [31:0] MOSI0  = 32'h0000_8F00;
    localparam logic [31:0] MOSI1  = 32'hA5A5_0F0F;
    localparam logic [5:0]  NBITS0 = 6'd15;
    localparam logic [5:0]  NBITS1 = 6'd31;

    logic                clk_in = 1'b0;
    logic                nrst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*DW-1:0]  req_mosi;
    logic [NREQ*NBW-1:0] req_nbits;
    logic [NREQ-1:0]     req_ack;
    logic [NREQ-1:0]     rsp_valid;
    logic [DW-1:0]       rsp_miso;
    logic                rsp_err;
    logic                busy;
    logic [DW-1:0]       spi_mosi_data;
    logic [NBW-1:0]      spi_nbits;
    logic                spi_request;
    logic                spi_ready;
    logic [DW-1:0]       spi_miso_data;

    int n_chk  = 0;
    int n_pass = 0;

    spi_txn_arbiter #(
        .NREQ           (NREQ),
        .DW             (DW),
        .NBW            (NBW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_in        (clk_in),
        .nrst          (nrst),
        .req_valid     (req_valid),
        .req_mosi      (req_mosi),
        .req_nbits     (req_nbits),
        .req_ack       (req_ack),
        .rsp_valid     (rsp_valid),
        .rsp_miso      (rsp_miso),
        .rsp_err       (rsp_err),
        .busy          (busy),
        .spi_mosi_data (spi_mosi_data),
        .spi_nbits     (spi_nbits),
        .spi_request   (spi_request),
        .spi_ready     (spi_ready),
        .spi_miso_data (spi_miso_data)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (req_ack != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // One complete transaction for the requester expected to win the next grant.
    task automatic run_txn(input string tag, input int who, input logic [31:0] miso);
        bit ok;
        wait_ack(ok);
        chk({tag, "_ack_seen"}, 32'(ok), 32'd1);
        chk({tag, "_ack"}, 32'(req_ack), 32'(1 << who));
        chk({tag, "_mosi"}, spi_mosi_data, (who == 0) ? MOSI0 : MOSI1);
        chk({tag, "_nbits"}, 32'(spi_nbits), 32'((who == 0) ? NBITS0 : NBITS1));
        step();
        chk({tag, "_spi_req"}, 32'(spi_request), 32'd1);
        chk({tag, "_ack_clr"}, 32'(req_ack), 32'd0);
        step();
        chk({tag, "_spi_req_clr"}, 32'(spi_request), 32'd0);
        spi_ready     = 1'b1;
        spi_miso_data = miso;
        step();
        spi_ready = 1'b0;
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(1 << who));
        chk({tag, "_rsp_miso"}, rsp_miso, miso);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        step();
        chk({tag, "_rsp_clr"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        bit seen;
        nrst          = 1'b0;
        req_valid     = '0;
        req_mosi      = {MOSI1, MOSI0};
        req_nbits     = {NBITS1, NBITS0};
        spi_ready     = 1'b0;
        spi_miso_data = '0;
        step();
        step();
        chk("rst_ack", 32'(req_ack), 32'd0);
        chk("rst_rsp", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_spi_req", 32'(spi_request), 32'd0);
        chk("rst_mosi", spi_mosi_data, 32'd0);
        chk("rst_nbits", 32'(spi_nbits), 32'd0);
        chk("rst_miso", rsp_miso, 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        nrst = 1'b1;
        step();

        // single request from requester 0
        req_valid = 2'b01;
        step();
        chk("single_ack", 32'(req_ack), 32'd1);
        chk("single_busy", 32'(busy), 32'd1);
        chk("single_nbits", 32'(spi_nbits), 32'd15);
        chk("single_mosi", spi_mosi_data, 32'h8F00);
        chk("single_no_req_yet", 32'(spi_request), 32'd0);
        req_valid = 2'b00;
        step();
        chk("single_spi_req", 32'(spi_request), 32'd1);
        chk("single_ack_clr", 32'(req_ack), 32'd0);
        step();
        chk("single_spi_req_clr", 32'(spi_request), 32'd0);
        spi_ready     = 1'b1;
        spi_miso_data = 32'hE5;
        step();
        spi_ready = 1'b0;
        chk("single_rsp", 32'(rsp_valid), 32'd1);
        chk("single_miso", rsp_miso, 32'hE5);
        step();
        chk("single_rsp_clr", 32'(rsp_valid), 32'd0);
        chk("single_idle", 32'(busy), 32'd0);
        chk("single_miso_hold", rsp_miso, 32'hE5);
        chk("single_nbits_hold", 32'(spi_nbits), 32'd15);

        // contention from reset: grants 0,1,0,1
        nrst = 1'b0;
        step();
        nrst      = 1'b1;
        req_valid = 2'b11;
        run_txn("rr0", 0, 32'h1111_0000);
        run_txn("rr1", 1, 32'h2222_0001);
        run_txn("rr2", 0, 32'h3333_0002);
        run_txn("rr3", 1, 32'h4444_0003);
        req_valid = 2'b00;

        // spi_ready asserted in IDLE and ISSUE must be ignored
        req_valid     = 2'b01;
        spi_ready     = 1'b1;
        spi_miso_data = 32'hDEAD_BEEF;
        step();
        chk("rdy_idle_ack", 32'(req_ack), 32'd1);
        chk("rdy_idle_rsp", 32'(rsp_valid), 32'd0);
        req_valid = 2'b00;
        step();
        chk("rdy_issue_rsp", 32'(rsp_valid), 32'd0);
        chk("rdy_issue_spi_req", 32'(spi_request), 32'd1);
        spi_ready = 1'b0;
        step();
        chk("rdy_wait_rsp", 32'(rsp_valid), 32'd0);
        chk("rdy_wait_busy", 32'(busy), 32'd1);
        spi_ready     = 1'b1;
        spi_miso_data = 32'h1234;
        step();
        spi_ready = 1'b0;
        chk("rdy_real_rsp", 32'(rsp_valid), 32'd1);
        chk("rdy_real_miso", rsp_miso, 32'h1234);
        step();

        // reset while in WAIT
        req_valid = 2'b10;
        step();
        chk("rstw_ack", 32'(req_ack), 32'd2);
        req_valid = 2'b00;
        step();
        step();
        nrst = 1'b0;
        step();
        nrst = 1'b1;
        chk("rstw_rsp", 32'(rsp_valid), 32'd0);
        chk("rstw_busy", 32'(busy), 32'd0);
        chk("rstw_miso", rsp_miso, 32'd0);
        chk("rstw_mosi", spi_mosi_data, 32'd0);
        chk("rstw_nbits", 32'(spi_nbits), 32'd0);
        chk("rstw_spi_req", 32'(spi_request), 32'd0);
        req_valid = 2'b11;
        step();
        chk("rstw_regrant", 32'(req_ack), 32'd1);
        chk("rstw_no_rsp", 32'(rsp_valid), 32'd0);
        req_valid = 2'b00;
        step();
        step();
        spi_ready     = 1'b1;
        spi_miso_data = 32'h55;
        step();
        spi_ready = 1'b0;
        chk("rstw_done_rsp", 32'(rsp_valid), 32'd1);
        step();

`ifdef SPI_ARB_TIMEOUT_EN
        // watchdog expiry: 16 WAIT cycles, owner 1
        req_valid = 2'b10;
        step();
        chk("to_ack", 32'(req_ack), 32'd2);
        req_valid = 2'b00;
        step();
        chk("to_spi_req", 32'(spi_request), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (rsp_valid != '0) seen = 1'b1;
        end
        chk("to_early", 32'(seen), 32'd0);
        step();
        chk("to_rsp", 32'(rsp_valid), 32'd2);
        chk("to_err", 32'(rsp_err), 32'd1);
        chk("to_miso", rsp_miso, 32'd0);
        step();
        chk("to_err_clr", 32'(rsp_err), 32'd0);

        // ready on the 16th WAIT cycle wins over expiry
        req_valid = 2'b01;
        step();
        chk("tie_ack", 32'(req_ack), 32'd1);
        req_valid = 2'b00;
        step();
        for (int i = 0; i < 15; i++) step();
        spi_ready     = 1'b1;
        spi_miso_data = 32'hCAFE;
        step();
        spi_ready = 1'b0;
        chk("tie_rsp", 32'(rsp_valid), 32'd1);
        chk("tie_err", 32'(rsp_err), 32'd0);
        chk("tie_miso", rsp_miso, 32'hCAFE);
        step();
`else
        // without the watchdog WAIT never ends on its own
        req_valid = 2'b01;
        step();
        chk("nto_ack", 32'(req_ack), 32'd1);
        req_valid = 2'b00;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (rsp_valid != '0) seen = 1'b1;
        end
        chk("nto_no_rsp", 32'(seen), 32'd0);
        chk("nto_busy", 32'(busy), 32'd1);
        chk("nto_err", 32'(rsp_err), 32'd0);
        spi_ready     = 1'b1;
        spi_miso_data = 32'h77;
        step();
        spi_ready = 1'b0;
        chk("nto_rsp", 32'(rsp_valid), 32'd1);
        chk("nto_miso", rsp_miso, 32'h77);
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
